// File: rtl/golden_bus_master.sv
// rtl/golden_bus_master.sv - command-driven Z-bus initiator for the golden multiplier core
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   cmd_valid    command offered            cmd_ready  accepts command (IDLE only)
//   cmd_a/cmd_b  multiplicand / multiplier
//   start        to core, high during the four load cycles
//   z            shared bus, driven only in LOAD0..LOAD3
//   done         from core, product is on z while high
//   res_valid    result held for consumer   res_ready  consumer accepts result
//   res_data     captured product (0 on timeout)
//   res_timeout  1 = core never signalled done
//   busy         high in any state other than IDLE
module golden_bus_master #(
    parameter int unsigned       W       = 32,
    parameter logic [W-1:0]      INIT4   = '0,
    parameter logic [W-1:0]      INIT5   = W'(1),
    parameter int unsigned       TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic         start,
    inout  wire  [W-1:0] z,
    input  logic         done,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_timeout,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD0 = 3'd1,
        LOAD1 = 3'd2,
        LOAD2 = 3'd3,
        LOAD3 = 3'd4,
        WAIT  = 3'd5,
        HOLD  = 3'd6
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t       state, state_n;
    logic [W-1:0] z_q, z_n;
    logic         z_oe, z_oe_n;
    logic [W-1:0] b_q, b_n;
    logic [15:0]  cnt, cnt_n;
    logic         start_n, cmd_ready_n, busy_n;
    logic         res_valid_n, res_timeout_n;
    logic [W-1:0] res_data_n;

    // Drive data and enable are both flops, so the bus is released on the
    // same edge that leaves LOAD3 and immediately on reset.
    assign z = z_oe ? z_q : {W{1'bz}};

    // Outputs are computed from the next state so that every port is a flop
    // whose value matches the state it is entering.
    always_comb begin
        state_n       = state;
        z_n           = z_q;
        z_oe_n        = 1'b0;
        start_n       = 1'b0;
        b_n           = b_q;
        cnt_n         = cnt;
        res_valid_n   = res_valid;
        res_data_n    = res_data;
        res_timeout_n = res_timeout;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_n = LOAD0;
                    z_n     = cmd_a;
                    z_oe_n  = 1'b1;
                    start_n = 1'b1;
                    b_n     = cmd_b;
                end
            end
            LOAD0: begin
                state_n = LOAD1;
                z_n     = b_q;
                z_oe_n  = 1'b1;
                start_n = 1'b1;
            end
            LOAD1: begin
                state_n = LOAD2;
                z_n     = INIT4;
                z_oe_n  = 1'b1;
                start_n = 1'b1;
            end
            LOAD2: begin
                state_n = LOAD3;
                z_n     = INIT5;
                z_oe_n  = 1'b1;
                start_n = 1'b1;
            end
            LOAD3: begin
                state_n = WAIT;
                cnt_n   = '0;
            end
            WAIT: begin
                cnt_n = cnt + 16'd1;
                // done takes priority over an expiring counter
                if (done) begin
                    state_n       = HOLD;
                    res_data_n    = z;
                    res_timeout_n = 1'b0;
                    res_valid_n   = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_n       = HOLD;
                    res_data_n    = '0;
                    res_timeout_n = 1'b1;
                    res_valid_n   = 1'b1;
                end
            end
            HOLD: begin
                if (res_valid && res_ready) begin
                    state_n     = IDLE;
                    res_valid_n = 1'b0;
                    cnt_n       = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        cmd_ready_n = (state_n == IDLE);
        busy_n      = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            z_q         <= '0;
            z_oe        <= 1'b0;
            b_q         <= '0;
            cnt         <= '0;
            start       <= 1'b0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            z_q         <= z_n;
            z_oe        <= z_oe_n;
            b_q         <= b_n;
            cnt         <= cnt_n;
            start       <= start_n;
            cmd_ready   <= cmd_ready_n;
            busy        <= busy_n;
            res_valid   <= res_valid_n;
            res_data    <= res_data_n;
            res_timeout <= res_timeout_n;
        end
    end

endmodule

// File: tb/tb_golden_bus_master.sv
// tb/tb_golden_bus_master.sv - self-checking bench for golden_bus_master
module tb_golden_bus_master;

    localparam int          TO    = 8;
    localparam logic [31:0] INIT4 = 32'h0;
    localparam logic [31:0] INIT5 = 32'h1;
    localparam logic [31:0] PROBE = 32'hA5C3_5A3C;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic        start;
    wire  [31:0] z;
    logic        done;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_timeout;
    logic        busy;

    // Core-side driver: a released master lets the core value through untouched.
    logic        core_oe;
    logic [31:0] core_val;
    assign z = core_oe ? core_val : 32'bz;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    golden_bus_master #(.W(32), .INIT4(INIT4), .INIT5(INIT5), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .start(start), .z(z), .done(done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_timeout(res_timeout), .busy(busy)
    );

    // One full transaction. d = WAIT cycle index in which the core raises done
    // (d >= TO means never). Expectations come from the transaction rules:
    // four load words, then min(d+1, TO) WAIT cycles, then a held result.
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input int d,
                           input logic [31:0] val, input int hold, input bit chain,
                           input logic [31:0] na, input logic [31:0] nb);
        logic [31:0] words [4];
        bit          got_done;
        int          n_wait;
        logic [31:0] exp_data;
        logic        exp_to;
        int          k;
        words    = '{a, b, INIT4, INIT5};
        got_done = (d < TO);
        n_wait   = got_done ? d + 1 : TO;
        exp_data = got_done ? val : 32'h0;
        exp_to   = !got_done;

        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_timeout: got %b want 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (chain) begin
            cmd_a = na;
            cmd_b = nb;
        end else begin
            cmd_valid = 1'b0;
            cmd_a     = $urandom;
            cmd_b     = $urandom;
        end

        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (z !== words[i]) begin
                n_fail++;
                $display("FAIL load_z[%0d]: got %h want %h", i, z, words[i]);
            end
            n_checks++;
            if (start !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL load_ctl[%0d]: got start=%b busy=%b cmd_ready=%b want 1 1 0",
                         i, start, busy, cmd_ready);
            end
            done = ($urandom_range(0, 1) != 0);
            @(negedge clk);
        end

        for (int i = 0; i < n_wait; i++) begin
            core_oe  = 1'b1;
            core_val = (i == d) ? val : (((i % 2) != 0) ? PROBE : ~PROBE);
            done     = (i == d);
            #1;
            n_checks++;
            if (z !== core_val) begin
                n_fail++;
                $display("FAIL wait_z_released[%0d]: got %h want %h", i, z, core_val);
            end
            n_checks++;
            if (start !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL wait_ctl[%0d]: got start=%b res_valid=%b busy=%b want 0 0 1",
                         i, start, res_valid, busy);
            end
            @(negedge clk);
        end
        done    = 1'b0;
        core_oe = 1'b0;

        for (int i = 0; i <= hold; i++) begin
            res_ready = (i == hold);
            core_oe   = 1'b1;
            core_val  = ((i % 2) != 0) ? PROBE : ~PROBE;
            done      = ($urandom_range(0, 1) != 0);
            #1;
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== exp_data || res_timeout !== exp_to) begin
                n_fail++;
                $display("FAIL hold_result[%0d]: got v=%b data=%h to=%b want 1 %h %b",
                         i, res_valid, res_data, res_timeout, exp_data, exp_to);
            end
            n_checks++;
            if (z !== core_val || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_bus[%0d]: got z=%h cmd_ready=%b busy=%b want %h 0 1",
                         i, z, cmd_ready, busy, core_val);
            end
            @(negedge clk);
        end
        res_ready = 1'b0;
        done      = 1'b0;
        core_oe   = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || res_data !== exp_data) begin
            n_fail++;
            $display("FAIL back_to_idle: got v=%b busy=%b cmd_ready=%b data=%h want 0 0 1 %h",
                     res_valid, busy, cmd_ready, res_data, exp_data);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
        done = 1'b0; res_ready = 1'b0;
        core_oe = 1'b1; core_val = PROBE;
        #2;
        n_checks++;
        if (z !== PROBE) begin
            n_fail++;
            $display("FAIL reset_z_probe: got %h want %h", z, PROBE);
        end
        core_val = ~PROBE;
        #1;
        n_checks++;
        if (z !== ~PROBE) begin
            n_fail++;
            $display("FAIL reset_z_probe_inv: got %h want %h", z, ~PROBE);
        end
        n_checks++;
        if (start !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b0 ||
            res_data !== 32'h0 || res_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got start=%b v=%b rdy=%b busy=%b data=%h to=%b want all 0",
                     start, res_valid, cmd_ready, busy, res_data, res_timeout);
        end
        core_oe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_load_and_capture;
        run_cmd(32'd2, 32'd2, 5, 32'h0000_0004, 3, 1'b0, '0, '0);
    endtask

    task automatic test_timeout;
        run_cmd($urandom, $urandom, TO + 5, 32'hDEAD_BEEF, 1, 1'b0, '0, '0);
    endtask

    task automatic test_done_boundaries;
        run_cmd($urandom, $urandom, TO - 1, 32'h1234_5678, 0, 1'b0, '0, '0);
        run_cmd($urandom, $urandom, 0, 32'h8765_4321, 2, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid_load;
        cmd_valid = 1'b1; cmd_a = 32'h7; cmd_b = 32'h9;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (z !== INIT4 || start !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_load2: got z=%h start=%b want %h 1", z, start, INIT4);
        end
        #2;
        rst = 1'b0;
        core_oe = 1'b1; core_val = PROBE;
        #1;
        n_checks++;
        if (z !== PROBE || start !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got z=%h start=%b busy=%b v=%b want %h 0 0 0",
                     z, start, busy, res_valid, PROBE);
        end
        core_val = ~PROBE;
        #1;
        n_checks++;
        if (z !== ~PROBE) begin
            n_fail++;
            $display("FAIL midrst_z_inv: got %h want %h", z, ~PROBE);
        end
        core_oe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_cmd(32'd3, 32'd5, 2, 32'd15, 1, 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back;
        run_cmd(32'h1111_0001, 32'h2222_0002, 3, 32'hCAFE_0001, 2, 1'b1,
                32'h3333_0003, 32'h4444_0004);
        run_cmd(32'h3333_0003, 32'h4444_0004, 1, 32'hCAFE_0002, 0, 1'b0, '0, '0);
    endtask

    task automatic test_random;
        logic [31:0] a, b, na, nb;
        bit          ch;
        a = $urandom; b = $urandom;
        for (int n = 0; n < 12; n++) begin
            na = $urandom; nb = $urandom;
            ch = ($urandom_range(0, 1) != 0);
            run_cmd(a, b, int'($urandom_range(0, TO + 2)), $urandom,
                    int'($urandom_range(0, 3)), ch, na, nb);
            if (ch) begin
                a = na; b = nb;
            end else begin
                a = $urandom; b = $urandom;
            end
        end
    endtask

    initial begin
        test_reset;
        test_load_and_capture;
        test_timeout;
        test_done_boundaries;
        test_reset_mid_load;
        test_back_to_back;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
